// File: rtl/psdifir_i2s_tx_pkg.sv
// psdifir_i2s_tx_pkg
//   Shared definitions for the I2S transmit path of the psdifir audio chain:
//   default widths, the transmit FSM state encoding and a constant clog2
//   helper usable in port/parameter declarations.
package psdifir_i2s_tx_pkg;

  localparam int DEF_SAMPLE_W   = 18;
  localparam int DEF_SLOT_W     = 32;
  localparam int DEF_BCLK_DIV   = 32;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tx_state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/psdifir_pair_fifo.sv
// psdifir_pair_fifo
//   Synchronous FIFO holding stereo pairs {left,right} between the FIR result
//   strobes and the fixed-rate I2S frame. DEPTH must be a power of two so the
//   pointers wrap naturally.
// Ports
//   clk, rst_n        clock / asynchronous active-low reset (flushes the FIFO)
//   wr_en, wr_data    write request; ignored while full
//   rd_en, rd_data    pop request; rd_data shows the head entry combinationally
//   full, empty       status
//   level             number of entries stored (0..DEPTH)
module psdifir_pair_fifo
  import psdifir_i2s_tx_pkg::*;
#(
  parameter int WIDTH = 2 * DEF_SAMPLE_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   level
);

  localparam int PTR_W = clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LEVEL = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   level_reg;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (level_reg == FULL_LEVEL);
  assign empty   = (level_reg == '0);
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr_reg];
  assign level   = level_reg;

  // Storage carries no reset: stale contents are unreachable once level is 0.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/psdifir_i2s_tx.sv
// psdifir_i2s_tx
//   Serialises filtered stereo pairs from the psdifir core onto an I2S link.
//   A small pair FIFO decouples FIR result timing from the fixed frame rate.
//   Build option: define PSDIFIR_I2S_TX_HOLD_EN to retransmit the last popped
//   pair on underrun; otherwise an all-zero pair is sent.
// Ports
//   clockext100MHz  system clock (rising edge)
//   reset           asynchronous active-low reset
//   tx_enable       1 = run link, 0 = finish current frame then idle
//   dataout_ready   1-cycle strobe qualifying left_out/right_out
//   left_out        left sample (two's complement, SAMPLE_W bits)
//   right_out       right sample
//   clr_flags       1-cycle strobe clearing overflow/underrun
//   i2s_bclk        bit clock
//   i2s_lrclk       word select (0 = left, 1 = right)
//   i2s_sdata       serial data, MSB first, changes with bclk falling
//   fifo_level      pairs currently buffered
//   overflow        sticky: strobe arrived while FIFO full
//   underrun        sticky: frame started with FIFO empty
module psdifir_i2s_tx
  import psdifir_i2s_tx_pkg::*;
#(
  parameter int SAMPLE_W   = DEF_SAMPLE_W,
  parameter int SLOT_W     = DEF_SLOT_W,
  parameter int BCLK_DIV   = DEF_BCLK_DIV,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        clockext100MHz,
  input  logic                        reset,
  input  logic                        tx_enable,
  input  logic                        dataout_ready,
  input  logic [SAMPLE_W-1:0]         left_out,
  input  logic [SAMPLE_W-1:0]         right_out,
  input  logic                        clr_flags,
  output logic                        i2s_bclk,
  output logic                        i2s_lrclk,
  output logic                        i2s_sdata,
  output logic [clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                        overflow,
  output logic                        underrun
);

  localparam int FRAME_W = 2 * SLOT_W;
  localparam int PAIR_W  = 2 * SAMPLE_W;
  localparam int CNT_W   = clog2(BCLK_DIV);
  localparam int BIT_W   = clog2(FRAME_W);
  localparam logic [CNT_W-1:0] RISE_CNT = CNT_W'(BCLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FALL_CNT = CNT_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] LR_FIRST = BIT_W'(SLOT_W - 1);
  localparam logic [BIT_W-1:0] LR_LAST  = BIT_W'(FRAME_W - 2);

  tx_state_t         state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [BIT_W-1:0]  bit_reg;
  logic [FRAME_W-1:0] shift_reg;
  logic              bclk_reg;
  logic              overflow_reg;
  logic              underrun_reg;

  logic              fifo_full, fifo_empty;
  logic              pop, load, underrun_set;
  logic [PAIR_W-1:0] head_pair, sub_pair, load_pair;
  logic              rise_tick, fall_tick, frame_end;

  psdifir_pair_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clockext100MHz),
    .rst_n   (reset),
    .wr_en   (dataout_ready),
    .wr_data ({left_out, right_out}),
    .rd_en   (pop),
    .rd_data (head_pair),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Lay a pair out as one I2S frame: each sample left-justified in its slot.
  function automatic logic [FRAME_W-1:0] pack_frame(input logic [PAIR_W-1:0] pair);
    logic [FRAME_W-1:0] l_ext, r_ext;
    l_ext = FRAME_W'(pair[PAIR_W-1:SAMPLE_W]);
    r_ext = FRAME_W'(pair[SAMPLE_W-1:0]);
    return (l_ext << (FRAME_W - SAMPLE_W)) | (r_ext << (SLOT_W - SAMPLE_W));
  endfunction

`ifdef PSDIFIR_I2S_TX_HOLD_EN
  logic [PAIR_W-1:0] last_pair_reg;

  always_ff @(posedge clockext100MHz or negedge reset) begin
    if (!reset) begin
      last_pair_reg <= '0;
    end else if (pop) begin
      last_pair_reg <= head_pair;
    end
  end

  assign sub_pair = last_pair_reg;
`else
  assign sub_pair = '0;
`endif

  assign rise_tick = (cnt_reg == RISE_CNT);
  assign fall_tick = (cnt_reg == FALL_CNT);
  assign frame_end = fall_tick && (bit_reg == LAST_BIT);
  assign load_pair = fifo_empty ? sub_pair : head_pair;

  always_comb begin
    state_next   = state_reg;
    pop          = 1'b0;
    load         = 1'b0;
    underrun_set = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (tx_enable && !fifo_empty) begin
          state_next = ST_RUN;
          pop        = 1'b1;
          load       = 1'b1;
        end
      end
      ST_RUN: begin
        if (frame_end) begin
          pop          = !fifo_empty;
          load         = 1'b1;
          underrun_set = fifo_empty;
        end
        if (!tx_enable) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The frame in flight always completes; re-enabling mid-frame resumes
        // normal popping at the next boundary.
        if (frame_end)      state_next = ST_IDLE;
        else if (tx_enable) state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clockext100MHz or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      bclk_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_next == ST_IDLE) begin
        cnt_reg   <= '0;
        bit_reg   <= '0;
        shift_reg <= '0;
        bclk_reg  <= 1'b0;
      end else if (state_reg == ST_IDLE) begin
        // Link start: left MSB is on sdata in the first RUN cycle, bclk
        // rises half a bit period later.
        cnt_reg   <= '0;
        bit_reg   <= '0;
        bclk_reg  <= 1'b0;
        shift_reg <= pack_frame(load_pair);
      end else begin
        cnt_reg <= fall_tick ? '0 : cnt_reg + 1'b1;
        if (rise_tick)      bclk_reg <= 1'b1;
        else if (fall_tick) bclk_reg <= 1'b0;
        if (fall_tick) begin
          bit_reg   <= frame_end ? '0 : bit_reg + 1'b1;
          shift_reg <= load ? pack_frame(load_pair) : (shift_reg << 1);
        end
      end
    end
  end

  // Flag set wins over a simultaneous clear.
  always_ff @(posedge clockext100MHz or negedge reset) begin
    if (!reset) begin
      overflow_reg <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      if (dataout_ready && fifo_full) overflow_reg <= 1'b1;
      else if (clr_flags)             overflow_reg <= 1'b0;
      if (underrun_set)               underrun_reg <= 1'b1;
      else if (clr_flags)             underrun_reg <= 1'b0;
    end
  end

  assign i2s_bclk  = bclk_reg;
  assign i2s_sdata = shift_reg[FRAME_W-1];
  // Word select leads each slot's MSB by one bit period.
  assign i2s_lrclk = (bit_reg >= LR_FIRST) && (bit_reg <= LR_LAST);
  assign overflow  = overflow_reg;
  assign underrun  = underrun_reg;

endmodule

// File: tb/tb_psdifir_i2s_tx.sv
`timescale 1ns/1ps
module tb_psdifir_i2s_tx;

  localparam int SAMPLE_W   = 18;
  localparam int SLOT_W     = 32;
  localparam int BCLK_DIV   = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int PAIR_W     = 2 * SAMPLE_W;
  localparam int FRAME_CYC  = 2 * SLOT_W * BCLK_DIV;

  typedef logic [PAIR_W-1:0] pair_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_enable = 1'b0;
  logic dataout_ready = 1'b0;
  logic clr_flags = 1'b0;
  logic [SAMPLE_W-1:0] left_out = '0;
  logic [SAMPLE_W-1:0] right_out = '0;
  logic i2s_bclk, i2s_lrclk, i2s_sdata;
  logic [2:0] fifo_level;
  logic overflow, underrun;

  always #5 clk = ~clk;

  psdifir_i2s_tx #(
    .SAMPLE_W   (SAMPLE_W),
    .SLOT_W     (SLOT_W),
    .BCLK_DIV   (BCLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clockext100MHz (clk),
    .reset          (reset),
    .tx_enable      (tx_enable),
    .dataout_ready  (dataout_ready),
    .left_out       (left_out),
    .right_out      (right_out),
    .clr_flags      (clr_flags),
    .i2s_bclk       (i2s_bclk),
    .i2s_lrclk      (i2s_lrclk),
    .i2s_sdata      (i2s_sdata),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .underrun       (underrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint unsigned observed, input longint unsigned expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // ---------------- I2S receiver (reference decoder) ----------------
  // A bit belongs to the channel indicated by word select one bclk earlier.
  pair_t   rx_q[$];
  int      rx_tz_bad = 0;
  longint  rx_rises = 0;
  time     rx_bclk_period = 0;
  time     rx_last_rise = 0;
  time     lr_period = 0;
  time     lr_last = 0;

  initial begin : i2s_receiver
    logic [SAMPLE_W-1:0] word;
    logic [SAMPLE_W-1:0] left_word;
    int   pos;
    logic prev_lr, ch, cur_ch;
    word = '0; left_word = '0; pos = 0; prev_lr = 1'b0; cur_ch = 1'b0;
    forever begin
      @(posedge i2s_bclk or negedge reset);
      if (!reset) begin
        word = '0; pos = 0; prev_lr = 1'b0; cur_ch = 1'b0; rx_last_rise = 0;
      end else begin
        rx_rises++;
        if (rx_last_rise != 0) rx_bclk_period = $time - rx_last_rise;
        rx_last_rise = $time;
        ch = prev_lr;
        if (ch != cur_ch) begin
          cur_ch = ch; pos = 0; word = '0;
        end
        if (pos < SAMPLE_W) word = {word[SAMPLE_W-2:0], i2s_sdata};
        else if (i2s_sdata) rx_tz_bad++;
        pos++;
        if (pos == SLOT_W) begin
          if (!ch) left_word = word;
          else begin
            rx_q.push_back({left_word, word});
            $display("rx frame %0d: left=%05h right=%05h", rx_q.size() - 1, left_word, word);
          end
          word = '0;
        end
        prev_lr = i2s_lrclk;
      end
    end
  end

  initial begin : lr_meter
    forever begin
      @(posedge i2s_lrclk);
      if (lr_last != 0) lr_period = $time - lr_last;
      lr_last = $time;
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe(input pair_t p, input logic clr);
    dataout_ready = 1'b1;
    left_out  = p[PAIR_W-1:SAMPLE_W];
    right_out = p[SAMPLE_W-1:0];
    clr_flags = clr;
    tick();
    dataout_ready = 1'b0;
    clr_flags = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
  endtask

  task automatic wait_rx(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (rx_q.size() < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, longint'(rx_q.size() >= target), 1);
  endtask

  task automatic wait_idle(input string tag);
    int low, n;
    low = 0; n = 0;
    while (low < 80 && n < 6000) begin
      tick();
      n++;
      if (i2s_bclk) low = 0;
      else low++;
    end
    check(tag, longint'(low >= 80), 1);
  endtask

  function automatic pair_t rand_pair();
    return {SAMPLE_W'($urandom), SAMPLE_W'($urandom)};
  endfunction

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_bclk"},  i2s_bclk, 0);
    check({pfx, "_lrclk"}, i2s_lrclk, 0);
    check({pfx, "_sdata"}, i2s_sdata, 0);
    check({pfx, "_level"}, fifo_level, 0);
    check({pfx, "_ovf"},   overflow, 0);
    check({pfx, "_udr"},   underrun, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    pair_t  model_q[$];
    pair_t  sent[$];
    pair_t  sub_pair;
    pair_t  p;
    int     base, accepted, n, gap, retained;
    longint rises0;

    // Reset held with strobes and tx_enable active: nothing may move.
    #2 reset = 1'b0;
    tx_enable = 1'b1;
    cycles(2);
    for (int i = 0; i < 5; i++) strobe(rand_pair(), 1'b0);
    check_outputs_zero("in_reset");
    tx_enable = 1'b0;
    reset = 1'b1;
    cycles(2);
    check_outputs_zero("after_release");

    // Fill while idle: 4 accepted, 5th dropped; its strobe also carries
    // clr_flags, and the set must win.
    for (int i = 0; i < 5; i++) begin
      p = (i == 0) ? {18'h2AAAA, 18'h15555} : rand_pair();
      strobe(p, (i == 4));
      if (model_q.size() < FIFO_DEPTH) model_q.push_back(p);
      check($sformatf("fill_level%0d", i), fifo_level, model_q.size());
      if (i == 3) check("ovf_before_full_write", overflow, 0);
    end
    check("ovf_set_beats_clr", overflow, 1);
    rises0 = rx_rises;
    cycles(200);
    check("idle_no_bclk", rx_rises - rises0, 0);
    check("idle_level_kept", fifo_level, 4);
    pulse_clr();
    check("ovf_cleared", overflow, 0);

`ifdef PSDIFIR_I2S_TX_HOLD_EN
    sub_pair = model_q[FIFO_DEPTH-1];
`else
    sub_pair = '0;
`endif

    // Run: four queued frames, then an underrun frame.
    base = rx_q.size();
    tx_enable = 1'b1;
    wait_rx(base + 4, 4 * FRAME_CYC + 200, "rx_four_frames");
    check("no_underrun_yet", underrun, 0);
    check("bclk_period_ns", rx_bclk_period, 320);
    check("lrclk_period_ns", lr_period, 64 * 320);
    for (int i = 0; i < 4; i++) check($sformatf("frameA%0d", i), rx_q[base + i], model_q[i]);
    wait_rx(base + 5, FRAME_CYC + 200, "rx_underrun_frame");
    check("underrun_pair", rx_q[base + 4], sub_pair);
    check("underrun_flag", underrun, 1);
    check("underrun_level", fifo_level, 0);
    tx_enable = 1'b0;
    wait_idle("idle_after_underrun");
    pulse_clr();
    check("udr_cleared", underrun, 0);

    // Streaming: writes paced so the FIFO neither fills nor empties.
    base = rx_q.size();
    accepted = 0;
    n = 0;
    tx_enable = 1'b1;
    while ((rx_q.size() - base) < 5 && n < 8 * FRAME_CYC) begin
      if (accepted - (rx_q.size() - base) <= 2) begin
        gap = $urandom_range(1, 300);
        cycles(gap);
        p = rand_pair();
        strobe(p, 1'b0);
        n += gap + 1;
        sent.push_back(p);
        accepted++;
      end else begin
        tick();
        n++;
      end
    end
    check("stream_five_frames", longint'((rx_q.size() - base) >= 5), 1);
    // Drop enable early in frame six; it must still complete.
    cycles(300);
    tx_enable = 1'b0;
    wait_rx(base + 6, FRAME_CYC + 200, "drain_completes");
    wait_idle("idle_after_drain");
    check("drain_no_extra_frame", rx_q.size(), base + 6);
    check("drain_level_retained", fifo_level, accepted - 6);
    check("drain_no_underrun", underrun, 0);
    check("drain_lrclk_low", i2s_lrclk, 0);
    check("drain_sdata_low", i2s_sdata, 0);
    for (int i = 0; i < 6; i++) check($sformatf("frameB%0d", i), rx_q[base + i], sent[i]);

    // Restart from retained pairs, then reset inside the right slot.
    p = rand_pair();
    strobe(p, 1'b0);
    sent.push_back(p);
    accepted++;
    retained = accepted - 6;
    check("restart_level", fifo_level, retained);
    base = rx_q.size();
    tx_enable = 1'b1;
    wait_rx(base + 1, FRAME_CYC + 200, "restart_frame");
    check("restart_pair", rx_q[base], sent[6]);
    n = 0;
    while (!i2s_lrclk && n < FRAME_CYC) begin
      tick();
      n++;
    end
    check("reached_right_slot", i2s_lrclk, 1);
    cycles(100);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    cycles(3);
    reset = 1'b1;
    base = rx_q.size();
    rises0 = rx_rises;
    cycles(50);
    check("post_reset_idle_bclk", rx_rises - rises0, 0);
    check("post_reset_level", fifo_level, 0);
    p = rand_pair();
    strobe(p, 1'b0);
    wait_rx(base + 1, FRAME_CYC + 200, "post_reset_frame");
    check("post_reset_pair", rx_q[base], p);
    check("post_reset_no_udr_yet", underrun, 0);
    cycles(40);
    check("post_reset_udr", underrun, 1);
    tx_enable = 1'b0;
    wait_idle("final_idle");
    check("trailing_zeros_bad_bits", rx_tz_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
